// File: rtl/sw_debounce_if.sv
// Switch-conditioning bus: raw switch pins and sticky-flag clear in, debounced
// levels, edge pulses and sticky change flags out.
// Ports: slave = conditioning block side, master = consumer/driver side.
interface sw_debounce_if #(
  parameter int WIDTH = 17
);
  logic [WIDTH-1:0] i_sw_raw;    // raw asynchronous switch/key pins
  logic             i_clr_en;    // clear strobe for sticky flags
  logic [WIDTH-1:0] i_clr_mask;  // which sticky flags to clear
  logic [WIDTH-1:0] o_io_sw;     // debounced stable levels
  logic [WIDTH-1:0] o_sw_rise;   // one-cycle 0->1 pulse per bit
  logic [WIDTH-1:0] o_sw_fall;   // one-cycle 1->0 pulse per bit
  logic [WIDTH-1:0] o_sw_event;  // sticky change flag per bit
  logic             o_any_event; // OR of o_sw_event

  modport slave (
    input  i_sw_raw, i_clr_en, i_clr_mask,
    output o_io_sw, o_sw_rise, o_sw_fall, o_sw_event, o_any_event
  );

  modport master (
    output i_sw_raw, i_clr_en, i_clr_mask,
    input  o_io_sw, o_sw_rise, o_sw_fall, o_sw_event, o_any_event
  );
endinterface

// File: rtl/sw_debounce.sv
// Switch debouncer: per-bit SYNC_STAGES synchroniser plus stability counter;
// a held level reaches o_io_sw SYNC_STAGES+DB_CYCLES edges after first sampled.
// Ports: clk_i/rst_i (async active-high), bus (slave modport) carrying the
// raw pins, sticky-flag clear, stable levels, rise/fall pulses and flags.
module sw_debounce #(
  parameter int WIDTH       = 17,
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 500000,
  localparam int CNT_W      = $clog2(DB_CYCLES + 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  sw_debounce_if.slave    bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
  logic [WIDTH-1:0][CNT_W-1:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0]                  stable_q, stable_d;
  logic [WIDTH-1:0]                  rise_q, rise_d;
  logic [WIDTH-1:0]                  fall_q, fall_d;
  logic [WIDTH-1:0]                  event_q, event_d;
  logic [WIDTH-1:0]                  sync_w;

  assign sync_w = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = bus.i_sw_raw;
    for (int s = 1; s < SYNC_STAGES; s++) begin
      sync_d[s] = sync_q[s-1];
    end
  end

  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    rise_d   = '0;
    fall_d   = '0;
    for (int k = 0; k < WIDTH; k++) begin
      if (sync_w[k] == stable_q[k]) begin
        // Any return to the stable value restarts the stability count.
        cnt_d[k] = '0;
      end else if (cnt_q[k] == CNT_LAST) begin
        stable_d[k] = sync_w[k];
        cnt_d[k]    = '0;
        rise_d[k]   = sync_w[k];
        fall_d[k]   = ~sync_w[k];
      end else begin
        cnt_d[k] = cnt_q[k] + CNT_W'(1);
      end
    end
    // A new change on the same edge as a clear keeps the flag set.
    event_d = (event_q & ~({WIDTH{bus.i_clr_en}} & bus.i_clr_mask))
            | rise_d | fall_d;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      stable_q <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      event_q  <= '0;
    end else begin
      sync_q   <= sync_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      event_q  <= event_d;
    end
  end

  assign bus.o_io_sw     = stable_q;
  assign bus.o_sw_rise   = rise_q;
  assign bus.o_sw_fall   = fall_q;
  assign bus.o_sw_event  = event_q;
  assign bus.o_any_event = |event_q;

endmodule

// File: doc/sw_debounce.md
Name: sw_debounce

Overview:
- Input-conditioning stage directly upstream of the load/store unit's switch input.
- Synchronises each of the 17 raw board switches/keys into clk_i and rejects bounce with a per-bit stability counter.
- Drives a clean level vector that the LSU samples as i_io_sw.
- Also provides per-bit rise/fall pulses and sticky change flags, with a masked clear, for software polling.

Parameters:
- WIDTH, 17, number of switch bits conditioned.
- SYNC_STAGES, 2, flip-flop stages in each bit's synchroniser; legal range ≥2.
- DB_CYCLES, 500000, consecutive clk_i cycles a synchronised bit must differ from its stable value before the stable value changes; legal range ≥1.
- CNT_W, $clog2(DB_CYCLES+1), width of each per-bit counter (derived; never overridden).

Ports:
- clk_i  input  1  system clock.
- rst_i  input  1  asynchronous, active-high reset.
- i_sw_raw  input  WIDTH  raw asynchronous switch/key pins.
- i_clr_en  input  1  clear strobe for the sticky flags.
- i_clr_mask  input  WIDTH  bits of o_sw_event cleared when i_clr_en=1.
- o_io_sw  output  WIDTH  debounced stable levels, to LSU i_io_sw.
- o_sw_rise  output  WIDTH  one-cycle pulse when the stable bit goes 0->1.
- o_sw_fall  output  WIDTH  one-cycle pulse when the stable bit goes 1->0.
- o_sw_event  output  WIDTH  sticky flag per bit, set on any stable change.
- o_any_event  output  1  OR-reduction of o_sw_event.

Behaviour:
- Reset (rst_i=1, asynchronous): all synchroniser flops, counters, o_io_sw, o_sw_rise, o_sw_fall and o_sw_event go to 0 immediately. Consequently o_any_event=0.
- No reset synchroniser inside this block; deassertion is synchronised at top level.
- Synchroniser: sync[k] is the output of a SYNC_STAGES-deep flop chain on i_sw_raw[k]. No logic between stages.
- Per-bit state: stable[k] (drives o_io_sw[k]) and cnt[k] (CNT_W bits).
- Each clk_i edge, per bit k:
  - If sync[k]==stable[k]: cnt[k]<=0. This is glitch rejection: any return to the stable value restarts the count.
  - Else if cnt[k]==DB_CYCLES-1:
    - stable[k]<=sync[k] and cnt[k]<=0.
    - o_sw_rise[k]<=sync[k], o_sw_fall[k]<=~sync[k], for exactly that one next cycle.
  - Else: cnt[k]<=cnt[k]+1.
- o_sw_rise/o_sw_fall are registered and are 0 in every cycle not immediately following a stable change. Rise and fall are never both 1 for the same bit.
- Latency: a raw level held constant changes o_io_sw SYNC_STAGES+DB_CYCLES rising edges after it is first sampled. The rise/fall pulse is coincident with the o_io_sw change.
- Counter saturation is never reached: the counter resets on update, so CNT_W covers DB_CYCLES-1.
- Bits are fully independent. Simultaneous changes on several bits each produce their own pulses in the same cycle.
- Sticky flags, per bit, each edge:
  - o_sw_event[k] <= (o_sw_event[k] & ~(i_clr_en & i_clr_mask[k])) | set[k], where set[k] is the condition that loads a rise/fall pulse this edge.
  - Set and clear on the same edge: set wins, flag stays 1.
  - i_clr_en with a zero mask has no effect.
- o_any_event is combinational OR of o_sw_event.
- Power-up with a switch already high: after reset release the bit debounces 0->1 normally, producing one o_sw_rise pulse and setting o_sw_event. Software clears it at boot.
- Reset mid-count: the counter and the pending change are discarded. The count restarts from 0 after release.
- DB_CYCLES=1: stable follows sync one edge after it differs, giving latency SYNC_STAGES+1.

Test Plan (bench uses WIDTH=17, SYNC_STAGES=2, DB_CYCLES=4):
- Reset then i_sw_raw=0 -> all outputs 0. Toggle rst_i=1 mid-cycle -> outputs clear without waiting for a clock edge.
- i_sw_raw[0] 0->1 held -> o_io_sw[0]=1 exactly 6 edges later; o_sw_rise[0]=1 for one cycle on that same cycle; o_sw_event[0]=1; o_any_event=1.
- Bounce i_sw_raw[3] as 1 for 3 cycles, 0 for 1, then 1 held -> no change until 4 consecutive differing synced cycles; one rise pulse only, timed from the final 0->1.
- Glitch of 3 cycles high on i_sw_raw[5] -> o_io_sw[5] stays 0; no pulse; o_sw_event[5] stays 0.
- i_sw_raw=17'h1FFFF, then after settling 17'h00000 -> all 17 bits fall together; o_sw_fall=17'h1FFFF for one cycle.
- Sticky handling:
  - With o_sw_event=17'h00009: i_clr_en=1, i_clr_mask=17'h00001 -> o_sw_event=17'h00008.
  - Clear bit 3 on the same edge its new rise is registered -> bit 3 remains 1.
  - Assert rst_i while bit 2 has counted 3 of 4 -> after release, bit 2 needs 6 fresh edges to change.
